mont_domain_exit: RTL

- Iterative radix-2 Montgomery reducer for the NTT datapath.
- Converts a Montgomery-form coefficient back to normal form: out_c = in_a * R^-1 mod Q, with R = 2^K.
- This is the exit-side counterpart of the Montgomery multiplier and sits at the NTT/INTT output boundary.
- Uses valid/ready handshakes on both sides and processes one coefficient at a time.

---
 rtl/mont_domain_exit_if.sv | 23 ++
 rtl/mont_domain_exit.sv | 115 +++++++++++
 2 files changed

// File: rtl/mont_domain_exit_if.sv
// rtl/mont_domain_exit_if.sv - operand/result handshake bundle for the Montgomery domain converter
interface mont_domain_exit_if #(
    parameter int W = 17
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_q;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_c;
    logic         busy;

    modport master (
        output in_valid, in_a, in_q, out_ready,
        input  in_ready, out_valid, out_c, busy
    );

    modport slave (
        input  in_valid, in_a, in_q, out_ready,
        output in_ready, out_valid, out_c, busy
    );
endinterface

// File: rtl/mont_domain_exit.sv
// rtl/mont_domain_exit.sv - iterative radix-2 Montgomery reducer, out_c = in_a * 2^-K mod Q
// Optional MONT_DOMAIN_ENTRY_EN adds a to_mont port selecting out_c = in_a * 2^K mod Q.
module mont_domain_exit #(
    parameter int W = 17,
    parameter int K = 13
) (
    input  logic              clk,
    input  logic              reset,
`ifdef MONT_DOMAIN_ENTRY_EN
    input  logic              to_mont,
`endif
    mont_domain_exit_if.slave bus
);
    localparam int CW = $clog2(K + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t         state, state_n;
    logic [W:0]     t, t_n, t_iter;
    logic [W-1:0]   q_r, q_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [W-1:0]   out_c_r, out_c_n;
    logic           out_valid_r, out_valid_n;
    logic [W:0]     q_ext, exit_sum, exit_t, fix_diff;

    assign q_ext    = {1'b0, q_r};
    // t < Q < 2^W keeps the W+1 bit sum from overflowing
    assign exit_sum = t + q_ext;
    assign exit_t   = t[0] ? (exit_sum >> 1) : (t >> 1);
    assign fix_diff = t - q_ext;

`ifdef MONT_DOMAIN_ENTRY_EN
    logic       mode_r, mode_n;
    logic [W:0] dbl, entry_t;

    assign dbl     = {t[W-1:0], 1'b0};
    assign entry_t = (dbl >= q_ext) ? (dbl - q_ext) : dbl;
    assign t_iter  = mode_r ? entry_t : exit_t;
`else
    assign t_iter  = exit_t;
`endif

    always_comb begin
        state_n     = state;
        t_n         = t;
        q_n         = q_r;
        cnt_n       = cnt;
        out_c_n     = out_c_r;
        out_valid_n = out_valid_r;
`ifdef MONT_DOMAIN_ENTRY_EN
        mode_n      = mode_r;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    t_n     = {1'b0, bus.in_a};
                    q_n     = bus.in_q;
                    cnt_n   = '0;
                    state_n = ITER;
`ifdef MONT_DOMAIN_ENTRY_EN
                    mode_n  = to_mont;
`endif
                end
            end
            ITER: begin
                t_n   = t_iter;
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(K - 1)) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                out_c_n     = (t >= q_ext) ? fix_diff[W-1:0] : t[W-1:0];
                out_valid_n = 1'b1;
                state_n     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            t           <= '0;
            q_r         <= '0;
            cnt         <= '0;
            out_c_r     <= '0;
            out_valid_r <= 1'b0;
`ifdef MONT_DOMAIN_ENTRY_EN
            mode_r      <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            t           <= t_n;
            q_r         <= q_n;
            cnt         <= cnt_n;
            out_c_r     <= out_c_n;
            out_valid_r <= out_valid_n;
`ifdef MONT_DOMAIN_ENTRY_EN
            mode_r      <= mode_n;
`endif
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_c     = out_c_r;
endmodule
